// File: rtl/iot_event_sequencer_if.sv
// Device-status / counter-event bus for iot_event_sequencer.
// Optional active_count signal is present only when SHADOW_COUNT_EN is defined.
interface iot_event_sequencer_if #(
    parameter int N_DEV = 8
);
    localparam int ID_W  = $clog2(N_DEV);
    localparam int CNT_W = $clog2(N_DEV + 1);

    logic [N_DEV-1:0] dev_on;
    logic             stall;
    logic             change;
    logic             on_off;
    logic [ID_W-1:0]  dev_id;
    logic [N_DEV-1:0] active_mask;
    logic             pending;
`ifdef SHADOW_COUNT_EN
    logic [CNT_W-1:0] active_count;
`endif

    modport master (
        input  dev_on, stall,
        output change, on_off, dev_id, active_mask, pending
`ifdef SHADOW_COUNT_EN
        , output active_count
`endif
    );

    modport slave (
        output dev_on, stall,
        input  change, on_off, dev_id, active_mask, pending
`ifdef SHADOW_COUNT_EN
        , input active_count
`endif
    );
endinterface

// File: rtl/iot_event_sequencer.sv
// Serialises per-device power-state changes into single-cycle change/on_off events.
// Optional feature macro: SHADOW_COUNT_EN (adds registered active_count + consistency check).
module iot_event_sequencer #(
    parameter int N_DEV   = 8,
    parameter int GAP_W   = 4,
    parameter int MIN_GAP = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    iot_event_sequencer_if.master bus
);
    localparam int ID_W  = $clog2(N_DEV);
    localparam int CNT_W = $clog2(N_DEV + 1);

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    state_t           state, state_nxt;
    logic [N_DEV-1:0] mask_r, mask_nxt, mm;
    logic [ID_W-1:0]  last_grant, last_grant_nxt, g, idx_w;
    logic [ID_W-1:0]  dev_id_r, dev_id_nxt;
    logic             change_r, change_nxt, on_off_r, on_off_nxt;
    logic [GAP_W-1:0] gap, gap_nxt;
    logic             grant_vld, start_ok;
    int unsigned      idx;

    assign mm = bus.dev_on ^ mask_r;

    // Round-robin: first mismatching device after last_grant, wrapping to 0.
    always_comb begin
        g         = '0;
        grant_vld = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned i = 1; i <= N_DEV; i++) begin
            idx   = (32'(last_grant) + i) % N_DEV;
            idx_w = ID_W'(idx);
            if (!grant_vld && mm[idx_w]) begin
                grant_vld = 1'b1;
                g         = idx_w;
            end
        end
    end

    // GAP with an exhausted counter acts as IDLE, giving exactly MIN_GAP quiet cycles.
    always_comb begin
        state_nxt      = state;
        change_nxt     = 1'b0;
        on_off_nxt     = on_off_r;
        dev_id_nxt     = dev_id_r;
        mask_nxt       = mask_r;
        last_grant_nxt = last_grant;
        gap_nxt        = gap;
        start_ok       = 1'b0;
        case (state)
            IDLE: start_ok = 1'b1;
            EMIT: begin
                if (MIN_GAP == 0) begin
                    start_ok = 1'b1;
                end else begin
                    state_nxt = GAP;
                    gap_nxt   = GAP_W'(MIN_GAP - 1);
                end
            end
            GAP: begin
                if (gap == '0) start_ok = 1'b1;
                else           gap_nxt  = gap - GAP_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
        if (start_ok) begin
            if (grant_vld && !bus.stall) begin
                change_nxt     = 1'b1;
                on_off_nxt     = bus.dev_on[g];
                dev_id_nxt     = g;
                mask_nxt[g]    = bus.dev_on[g];
                last_grant_nxt = g;
                state_nxt      = EMIT;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            change_r   <= 1'b0;
            on_off_r   <= 1'b0;
            dev_id_r   <= '0;
            mask_r     <= '0;
            gap        <= '0;
            last_grant <= ID_W'(N_DEV - 1);
        end else begin
            state      <= state_nxt;
            change_r   <= change_nxt;
            on_off_r   <= on_off_nxt;
            dev_id_r   <= dev_id_nxt;
            mask_r     <= mask_nxt;
            gap        <= gap_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    assign bus.change      = change_r;
    assign bus.on_off      = on_off_r;
    assign bus.dev_id      = dev_id_r;
    assign bus.active_mask = mask_r;
    assign bus.pending     = |mm;

`ifdef SHADOW_COUNT_EN
    logic [CNT_W-1:0] cnt_r;

    always_ff @(posedge clk) begin
        if (rst)             cnt_r <= '0;
        else if (change_nxt) cnt_r <= on_off_nxt ? cnt_r + CNT_W'(1) : cnt_r - CNT_W'(1);
    end

    assign bus.active_count = cnt_r;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (CNT_W'($countones(mask_r)) == cnt_r)
                else $error("active_count %0d disagrees with popcount(active_mask)", cnt_r);
        end
    end
`endif
`endif
endmodule

// File: tb/tb_iot_event_sequencer.sv
// Directed self-checking bench for iot_event_sequencer (MIN_GAP=0 and MIN_GAP=3 instances).
module tb_iot_event_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    iot_event_sequencer_if #(.N_DEV(8)) bus0 ();
    iot_event_sequencer_if #(.N_DEV(8)) bus1 ();

    iot_event_sequencer #(.N_DEV(8), .GAP_W(4), .MIN_GAP(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    iot_event_sequencer #(.N_DEV(8), .GAP_W(4), .MIN_GAP(3)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus0.dev_on = 8'h00;
        bus0.stall  = 1'b0;
        bus1.dev_on = 8'h00;
        bus1.stall  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus0.dev_on = 8'hFF;
        bus0.stall  = 1'b0;
        bus1.dev_on = 8'h00;
        bus1.stall  = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (bus0.change !== 1'b0 || bus0.on_off !== 1'b0 || bus0.dev_id !== 3'd0 || bus0.active_mask !== 8'h00) begin
            $display("FAIL reset_outputs: change=%b on_off=%b dev_id=%0d mask=%h, want 0 0 0 00",
                     bus0.change, bus0.on_off, bus0.dev_id, bus0.active_mask);
        end else pass_cnt++;
        bus0.dev_on = 8'h00;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            total_cnt++;
            if (bus0.change !== 1'b0 || bus0.active_mask !== 8'h00 || bus0.pending !== 1'b0) begin
                $display("FAIL idle_quiet cycle %0d: change=%b mask=%h pending=%b, want 0 00 0",
                         c, bus0.change, bus0.active_mask, bus0.pending);
            end else pass_cnt++;
        end
    endtask

    task automatic test_single();
        do_reset();
        bus0.dev_on = 8'h01;
        #1;
        total_cnt++;
        if (bus0.pending !== 1'b1) $display("FAIL single_pending: got %b want 1", bus0.pending);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus0.change !== 1'b1 || bus0.on_off !== 1'b1 || bus0.dev_id !== 3'd0 || bus0.active_mask !== 8'h01) begin
            $display("FAIL single_on: change=%b on_off=%b dev_id=%0d mask=%h, want 1 1 0 01",
                     bus0.change, bus0.on_off, bus0.dev_id, bus0.active_mask);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (bus0.change !== 1'b0) $display("FAIL single_on_width: change=%b want 0", bus0.change);
        else pass_cnt++;
        bus0.dev_on = 8'h00;
        tick();
        total_cnt++;
        if (bus0.change !== 1'b1 || bus0.on_off !== 1'b0 || bus0.dev_id !== 3'd0 || bus0.active_mask !== 8'h00) begin
            $display("FAIL single_off: change=%b on_off=%b dev_id=%0d mask=%h, want 1 0 0 00",
                     bus0.change, bus0.on_off, bus0.dev_id, bus0.active_mask);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (bus0.change !== 1'b0) $display("FAIL single_off_width: change=%b want 0", bus0.change);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_ids [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
        logic [2:0] ids [8];
        int         cyc [8];
        int         n = 0;
        do_reset();
        bus0.dev_on = 8'hA5;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus0.change === 1'b1) begin
                if (n < 8) begin
                    ids[n] = bus0.dev_id;
                    cyc[n] = c;
                end
                total_cnt++;
                if (bus0.on_off !== 1'b1) $display("FAIL b2b_on_off pulse %0d: got %b want 1", n, bus0.on_off);
                else pass_cnt++;
                n++;
            end
        end
        total_cnt++;
        if (n !== 4) $display("FAIL b2b_count: got %0d want 4", n);
        else pass_cnt++;
        if (n == 4) begin
            for (int i = 0; i < 4; i++) begin
                total_cnt++;
                if (ids[i] !== exp_ids[i]) $display("FAIL b2b_order pulse %0d: dev_id=%0d want %0d", i, ids[i], exp_ids[i]);
                else pass_cnt++;
            end
            total_cnt++;
            if (cyc[3] - cyc[0] !== 3) $display("FAIL b2b_spacing: span=%0d want 3", cyc[3] - cyc[0]);
            else pass_cnt++;
        end
        total_cnt++;
        if (bus0.active_mask !== 8'hA5) $display("FAIL b2b_mask: got %h want a5", bus0.active_mask);
        else pass_cnt++;
    endtask

    task automatic test_min_gap();
        logic [2:0] exp_ids [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
        logic [2:0] ids [8];
        int         cyc [8];
        int         n = 0;
        do_reset();
        bus1.dev_on = 8'hA5;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus1.change === 1'b1) begin
                if (n < 8) begin
                    ids[n] = bus1.dev_id;
                    cyc[n] = c;
                end
                n++;
            end
        end
        total_cnt++;
        if (n !== 4) $display("FAIL gap_count: got %0d want 4", n);
        else pass_cnt++;
        if (n == 4) begin
            for (int i = 0; i < 4; i++) begin
                total_cnt++;
                if (ids[i] !== exp_ids[i]) $display("FAIL gap_order pulse %0d: dev_id=%0d want %0d", i, ids[i], exp_ids[i]);
                else pass_cnt++;
            end
            for (int i = 0; i < 3; i++) begin
                total_cnt++;
                if (cyc[i+1] - cyc[i] - 1 !== 3)
                    $display("FAIL gap_idle after pulse %0d: idle=%0d want 3", i, cyc[i+1] - cyc[i] - 1);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (bus1.active_mask !== 8'hA5) $display("FAIL gap_mask: got %h want a5", bus1.active_mask);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        do_reset();
        bus0.stall  = 1'b1;
        bus0.dev_on = 8'h03;
        for (int c = 0; c < 5; c++) begin
            tick();
            total_cnt++;
            if (bus0.change !== 1'b0 || bus0.pending !== 1'b1)
                $display("FAIL stall_hold cycle %0d: change=%b pending=%b, want 0 1", c, bus0.change, bus0.pending);
            else pass_cnt++;
        end
        bus0.stall = 1'b0;
        tick();
        total_cnt++;
        if (bus0.change !== 1'b1 || bus0.dev_id !== 3'd0 || bus0.on_off !== 1'b1)
            $display("FAIL stall_release0: change=%b dev_id=%0d on_off=%b, want 1 0 1", bus0.change, bus0.dev_id, bus0.on_off);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus0.change !== 1'b1 || bus0.dev_id !== 3'd1 || bus0.on_off !== 1'b1)
            $display("FAIL stall_release1: change=%b dev_id=%0d on_off=%b, want 1 1 1", bus0.change, bus0.dev_id, bus0.on_off);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus0.change !== 1'b0 || bus0.active_mask !== 8'h03 || bus0.pending !== 1'b0)
            $display("FAIL stall_done: change=%b mask=%h pending=%b, want 0 03 0", bus0.change, bus0.active_mask, bus0.pending);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        do_reset();
        bus0.stall  = 1'b1;
        bus0.dev_on = 8'h10;
        tick();
        bus0.dev_on = 8'h00;
        tick();
        bus0.stall = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            total_cnt++;
            if (bus0.change !== 1'b0 || bus0.active_mask !== 8'h00 || bus0.pending !== 1'b0)
                $display("FAIL glitch cycle %0d: change=%b mask=%h pending=%b, want 0 00 0",
                         c, bus0.change, bus0.active_mask, bus0.pending);
            else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        int c = 0;
        do_reset();
        bus0.dev_on = 8'hFF;
        while (n < 3 && c < 20) begin
            tick();
            if (bus0.change === 1'b1) n++;
            c++;
        end
        total_cnt++;
        if (n !== 3) $display("FAIL midrst_prefix: got %0d pulses want 3", n);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        total_cnt++;
        if (bus0.change !== 1'b0 || bus0.active_mask !== 8'h00)
            $display("FAIL midrst_clear: change=%b mask=%h, want 0 00", bus0.change, bus0.active_mask);
        else pass_cnt++;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            total_cnt++;
            if (bus0.change !== 1'b1 || bus0.on_off !== 1'b1 || bus0.dev_id !== 3'(i))
                $display("FAIL midrst_pulse %0d: change=%b on_off=%b dev_id=%0d, want 1 1 %0d",
                         i, bus0.change, bus0.on_off, bus0.dev_id, i);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (bus0.change !== 1'b0 || bus0.active_mask !== 8'hFF)
            $display("FAIL midrst_final: change=%b mask=%h, want 0 ff", bus0.change, bus0.active_mask);
        else pass_cnt++;
`ifdef SHADOW_COUNT_EN
        total_cnt++;
        if (bus0.active_count !== 4'd8) $display("FAIL midrst_count: got %0d want 8", bus0.active_count);
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_min_gap();
        test_stall();
        test_glitch();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
